fixed_predictor_reconstructor: RTL

//  Downstream of the FLAC residual decoder. Rebuilds PCM samples of one FIXED subframe
//  (predictor order 0..4) from warm-up samples plus the decoded residual stream.

---
 rtl/flac_pkg.sv | 30 +++
 rtl/fixed_prediction.sv | 30 +++
 rtl/fixed_predictor_reconstructor.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/flac_pkg.sv
// Shared FLAC subframe decode types: FSM state encoding and fixed-predictor coefficients.
package flac_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WARMUP   = 2'd1,
    S_RESIDUAL = 2'd2
  } state_t;

  localparam int MAX_FIXED_ORDER = 4;

  typedef logic signed [3:0] coef_t;

  // Row = predictor order, column = tap weight on h1..h4 (h1 newest).
  localparam coef_t FIXED_COEF [MAX_FIXED_ORDER+1][MAX_FIXED_ORDER] = '{
    '{ 4'sd0,  4'sd0,  4'sd0,  4'sd0},
    '{ 4'sd1,  4'sd0,  4'sd0,  4'sd0},
    '{ 4'sd2, -4'sd1,  4'sd0,  4'sd0},
    '{ 4'sd3, -4'sd3,  4'sd1,  4'sd0},
    '{ 4'sd4, -4'sd6,  4'sd4, -4'sd1}
  };

  function automatic coef_t fixed_coef(input logic [3:0] order, input logic [1:0] tap);
    coef_t c;
    c = '0;
    if (order <= 4'(MAX_FIXED_ORDER)) c = FIXED_COEF[order[2:0]][tap];
    return c;
  endfunction

endpackage

// File: rtl/fixed_prediction.sv
// Combinational fixed-predictor: weighted sum of the last four samples for the given order.
// Zero latency, no flow control; unused taps carry zero weight.
module fixed_prediction
  import flac_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 20
) (
  input  logic signed [DATA_WIDTH-1:0] h1,
  input  logic signed [DATA_WIDTH-1:0] h2,
  input  logic signed [DATA_WIDTH-1:0] h3,
  input  logic signed [DATA_WIDTH-1:0] h4,
  input  logic        [3:0]            order,
  output logic signed [ACC_WIDTH-1:0]  pred
);

  logic signed [ACC_WIDTH-1:0] hx [MAX_FIXED_ORDER];

  always_comb begin
    hx[0] = ACC_WIDTH'(h1);
    hx[1] = ACC_WIDTH'(h2);
    hx[2] = ACC_WIDTH'(h3);
    hx[3] = ACC_WIDTH'(h4);
    pred  = '0;
    for (int k = 0; k < MAX_FIXED_ORDER; k++) begin
      pred = pred + ACC_WIDTH'(fixed_coef(order, 2'(k))) * hx[k];
    end
  end

endmodule

// File: rtl/fixed_predictor_reconstructor.sv
// Rebuilds PCM samples of one FLAC FIXED subframe from warm-ups plus residuals.
// One cycle from accepted input to oValid; accepts a sample every cycle, iEnable low stalls everything.
module fixed_predictor_reconstructor
  import flac_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                         iClock,
  input  logic                         iReset,
  input  logic                         iEnable,
  input  logic                         iStart,
  input  logic        [3:0]            iPredOrder,
  input  logic        [15:0]           iNSamples,
  input  logic signed [DATA_WIDTH-1:0] iWarmup,
  input  logic                         iWarmupValid,
  input  logic signed [DATA_WIDTH-1:0] iResidual,
  input  logic                         iResidualValid,
  output logic signed [DATA_WIDTH-1:0] oSample,
  output logic                         oValid,
  output logic                         oDone,
  output logic                         oError
);

  state_t                      state_q, state_nxt;
  logic        [3:0]           order_q, order_nxt;
  logic        [15:0]          nsamp_q, nsamp_nxt;
  logic        [15:0]          count_q, count_nxt;
  logic signed [DATA_WIDTH-1:0] h1_q, h2_q, h3_q, h4_q;
  logic signed [DATA_WIDTH-1:0] h1_nxt, h2_nxt, h3_nxt, h4_nxt;
  logic signed [DATA_WIDTH-1:0] sample_nxt;
  logic                        valid_nxt, done_nxt, error_nxt;

  logic signed [ACC_WIDTH-1:0]  pred;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [DATA_WIDTH-1:0] take_dat;
  logic                         take;

  fixed_prediction #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_pred (
    .h1   (h1_q),
    .h2   (h2_q),
    .h3   (h3_q),
    .h4   (h4_q),
    .order(order_q),
    .pred (pred)
  );

  // Wraps silently: only the low DATA_WIDTH bits are meaningful for legal streams.
  assign sum = pred + ACC_WIDTH'(iResidual);

  always_comb begin
    state_nxt  = state_q;
    order_nxt  = order_q;
    nsamp_nxt  = nsamp_q;
    count_nxt  = count_q;
    h1_nxt     = h1_q;
    h2_nxt     = h2_q;
    h3_nxt     = h3_q;
    h4_nxt     = h4_q;
    sample_nxt = oSample;
    valid_nxt  = 1'b0;
    done_nxt   = 1'b0;
    error_nxt  = 1'b0;
    take       = 1'b0;
    take_dat   = iWarmup;

    if (iEnable) begin
      unique case (state_q)
        S_IDLE: begin
          if (iStart) begin
            if (iPredOrder > 4'(MAX_FIXED_ORDER) || iNSamples < {12'd0, iPredOrder}) begin
              error_nxt = 1'b1;
            end else begin
              order_nxt = iPredOrder;
              nsamp_nxt = iNSamples;
              count_nxt = '0;
              h1_nxt    = '0;
              h2_nxt    = '0;
              h3_nxt    = '0;
              h4_nxt    = '0;
              // An empty subframe has nothing to emit, so stay idle.
              if (iNSamples == 16'd0)     state_nxt = S_IDLE;
              else if (iPredOrder != '0)  state_nxt = S_WARMUP;
              else                        state_nxt = S_RESIDUAL;
            end
          end
        end
        S_WARMUP: begin
          if (iWarmupValid) begin
            take     = 1'b1;
            take_dat = iWarmup;
          end
        end
        S_RESIDUAL: begin
          if (iResidualValid) begin
            take     = 1'b1;
            take_dat = sum[DATA_WIDTH-1:0];
          end
        end
        default: state_nxt = S_IDLE;
      endcase

      if (take) begin
        sample_nxt = take_dat;
        valid_nxt  = 1'b1;
        h4_nxt     = h3_q;
        h3_nxt     = h2_q;
        h2_nxt     = h1_q;
        h1_nxt     = take_dat;
        count_nxt  = count_q + 16'd1;
        if (count_nxt == nsamp_q) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else if (state_q == S_WARMUP && count_nxt == {12'd0, order_q}) begin
          state_nxt = S_RESIDUAL;
        end
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= S_IDLE;
      order_q <= '0;
      nsamp_q <= '0;
      count_q <= '0;
      h1_q    <= '0;
      h2_q    <= '0;
      h3_q    <= '0;
      h4_q    <= '0;
      oSample <= '0;
      oValid  <= 1'b0;
      oDone   <= 1'b0;
      oError  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      order_q <= order_nxt;
      nsamp_q <= nsamp_nxt;
      count_q <= count_nxt;
      h1_q    <= h1_nxt;
      h2_q    <= h2_nxt;
      h3_q    <= h3_nxt;
      h4_q    <= h4_nxt;
      oSample <= sample_nxt;
      oValid  <= valid_nxt;
      oDone   <= done_nxt;
      oError  <= error_nxt;
    end
  end

endmodule
